// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//   Shares the single write port of the 8x8 register file between requester 0
//   (ALU writeback) and requester 1 (memory/load writeback). A three-state FSM
//   (IDLE, WR0, WR1) grants one requester per cycle. GNT/WRITE/BUSY are
//   decoded from the state register. WADDR/WDATA are a combinational mux of
//   the granted requester's held address and data.
//
//   Optional feature macro: RR_ARB_EN
//     defined   : round-robin between simultaneous requests seen in IDLE
//     undefined : fixed priority, requester 0 wins in IDLE
//   In both modes WRx hands over to the other requester if it is waiting, so a
//   requester never waits more than one grant behind the other.
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DATA_WIDTH-1:0] DATA0,
  output logic                  GNT0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DATA1,
  output logic                  GNT1,
  output logic                  WRITE,
  output logic [ADDR_WIDTH-1:0] WADDR,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_e;

  state_e state_q, state_d;

`ifdef RR_ARB_EN
  // Index of the requester favoured at the next contested IDLE arbitration.
  // Only grants made from IDLE move it: the WRx -> WRy handoff is forced by
  // the other requester waiting, so it is not an arbitration decision. After
  // reset requester 0 is favoured.
  logic rr_ptr_q, rr_ptr_d;
`endif

  // Next-state selection: IDLE arbitrates, WRx hands over to the other side.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
`ifdef RR_ARB_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ0 && REQ1) begin
`ifdef RR_ARB_EN
          state_d = rr_ptr_q ? WR1 : WR0;
`else
          state_d = WR0;
`endif
        end else if (REQ0) begin
          state_d = WR0;
        end else if (REQ1) begin
          state_d = WR1;
        end
      end
      // The request consumed at this edge is never re-granted immediately.
      WR0:     state_d = REQ1 ? WR1 : IDLE;
      WR1:     state_d = REQ0 ? WR0 : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef RR_ARB_EN
    // Point at the loser of the grant just made from IDLE.
    if (state_q == IDLE && state_d != IDLE) begin
      rr_ptr_d = (state_d == WR0);
    end
`endif
  end

  // State (and round-robin pointer) registers; reset drops any in-flight write.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RESET) begin
      state_q <= IDLE;
`ifdef RR_ARB_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef RR_ARB_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Output decode: grant, write enable and write port mux follow the state.
  always_comb begin
    GNT0  = 1'b0;
    GNT1  = 1'b0;
    WRITE = 1'b0;
    WADDR = '0;
    WDATA = '0;
    case (state_q)
      WR0: begin
        GNT0  = 1'b1;
        WRITE = 1'b1;
        WADDR = ADDR0;
        WDATA = DATA0;
      end
      WR1: begin
        GNT1  = 1'b1;
        WRITE = 1'b1;
        WADDR = ADDR1;
        WDATA = DATA1;
      end
      default: ;
    endcase
    BUSY = (state_q != IDLE);
  end

endmodule
